pov_spi_loader: RTL and testbench

- Configuration controller for the raybox renderer: receives point-of-view (POV) and display-option updates over a 3-wire SPI link from an external host.
- Stages each update, then commits it atomically at the next frame boundary (vsync_n falling edge), so the wall tracer and row renderer never see a torn POV mid-frame.
- Sits between the chip pins and the POV/option inputs of the renderer core, in the same clock domain as the VGA timing (25 MHz).

---
 rtl/pov_spi_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_pov_spi_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_spi_loader.sv
// POV / display-option loader for the raybox renderer.
// A 3-wire SPI host writes POV or option updates into a staging register.
// Staged data is copied to the renderer-facing outputs only at the next frame
// boundary (vsync_n falling edge), so a frame never sees a torn POV.
module pov_spi_loader #(
    parameter int             W        = 16,
    parameter logic [W-1:0]   RESET_PX = 16'h0180,
    parameter logic [W-1:0]   RESET_PY = 16'h0180,
    parameter logic [W-1:0]   RESET_FX = 16'h0100,
    parameter logic [W-1:0]   RESET_FY = 16'h0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         vsync_n,
    input  logic         sclk,
    input  logic         mosi,
    input  logic         ss_n,
    output logic [W-1:0] player_x,
    output logic [W-1:0] player_y,
    output logic [W-1:0] facing_x,
    output logic [W-1:0] facing_y,
    output logic [2:0]   opts,
    output logic         pending,
    output logic         commit,
    output logic         err
);

    localparam int              SHR_W   = 4 * W;
    localparam int              CNT_W   = $clog2(SHR_W + 1);
    localparam logic [CNT_W-1:0] CMD_LEN = CNT_W'(8);
    localparam logic [CNT_W-1:0] POV_LEN = CNT_W'(SHR_W);
    localparam logic [CNT_W-1:0] OPT_LEN = CNT_W'(8);
    localparam logic [2:0]      RESET_OPTS = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA_POV,
        DATA_OPT,
        SKIP
    } state_t;

    // Counter increment that holds at the expected length; overrun is tracked separately.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

    // Synchroniser chains: _p0/_p1 are the metastability pair, _p2 is the edge-detect history.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic ss_p0,   ss_p1,   ss_p2;
    logic vs_p0,   vs_p1,   vs_p2;
    logic mosi_p0, mosi_p1;

    logic sclk_rise, ss_fall, ss_rise, frame_tick, bit_stb;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_lim;
    logic              over;
    logic [SHR_W-1:0]  shreg;
    logic [7:0]        cmd_byte;

    logic shift_en, cnt_clr, cnt_inc, over_set;
    logic load_pov, load_opt, err_set, err_clr;

    logic [W-1:0] stg_px, stg_py, stg_fx, stg_fy;
    logic [2:0]   stg_opts;

    // Bring the async pins into the clk domain; idle levels on reset so no false edges appear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
            ss_p0   <= 1'b1; ss_p1   <= 1'b1; ss_p2   <= 1'b1;
            vs_p0   <= 1'b1; vs_p1   <= 1'b1; vs_p2   <= 1'b1;
            mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;    sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
            ss_p0   <= ss_n;    ss_p1   <= ss_p0;   ss_p2   <= ss_p1;
            vs_p0   <= vsync_n; vs_p1   <= vs_p0;   vs_p2   <= vs_p1;
            mosi_p0 <= mosi;    mosi_p1 <= mosi_p0;
        end
    end

    // mosi_p1 has the same latency as sclk_p1, so it is the bit that goes with sclk_rise.
    assign sclk_rise  = sclk_p1 & ~sclk_p2;
    assign ss_fall    = ~ss_p1 & ss_p2;
    assign ss_rise    = ss_p1 & ~ss_p2;
    assign frame_tick = ~vs_p1 & vs_p2;
    assign bit_stb    = sclk_rise & ~ss_p1;
    assign cmd_byte   = {shreg[6:0], mosi_p1};

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and transaction control; deselect has priority over any coincident bit.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_lim   = CMD_LEN;
        over_set  = 1'b0;
        load_pov  = 1'b0;
        load_opt  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        if (ss_rise) begin
            state_nxt = IDLE;
            case (state)
                CMD: begin
                    if (bit_cnt != '0) err_set = 1'b1;
                end
                DATA_POV: begin
                    if (bit_cnt == POV_LEN && !over) begin
                        load_pov = 1'b1;
                        err_clr  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                DATA_OPT: begin
                    if (bit_cnt == OPT_LEN && !over) begin
                        load_opt = 1'b1;
                        err_clr  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                SKIP:    err_set = 1'b1;
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_nxt = CMD;
                        cnt_clr   = 1'b1;
                    end
                end
                CMD: begin
                    if (bit_stb) begin
                        shift_en = 1'b1;
                        if (bit_cnt == CMD_LEN - 1'b1) begin
                            cnt_clr = 1'b1;
                            case (cmd_byte)
                                8'h01:   state_nxt = DATA_POV;
                                8'h02:   state_nxt = DATA_OPT;
                                default: begin
                                    state_nxt = SKIP;
                                    err_set   = 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                DATA_POV: begin
                    cnt_lim = POV_LEN;
                    if (bit_stb) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (bit_cnt == POV_LEN) over_set = 1'b1;
                    end
                end
                DATA_OPT: begin
                    cnt_lim = OPT_LEN;
                    if (bit_stb) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (bit_cnt == OPT_LEN) over_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit counter and overrun flag for the current command/payload phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            over    <= 1'b0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
            over    <= 1'b0;
        end else begin
            if (cnt_inc)  bit_cnt <= sat_inc(bit_cnt, cnt_lim);
            if (over_set) over    <= 1'b1;
        end
    end

    // Receive shift register; contents only matter after an exact-length payload refills it.
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {shreg[SHR_W-2:0], mosi_p1};
    end

    // Staging register: each group is replaced only by a complete, well-formed write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_px   <= RESET_PX;
            stg_py   <= RESET_PY;
            stg_fx   <= RESET_FX;
            stg_fy   <= RESET_FY;
            stg_opts <= RESET_OPTS;
        end else begin
            if (load_pov) begin
                stg_px <= shreg[4*W-1:3*W];
                stg_py <= shreg[3*W-1:2*W];
                stg_fx <= shreg[2*W-1:W];
                stg_fy <= shreg[W-1:0];
            end
            if (load_opt) stg_opts <= shreg[2:0];
        end
    end

    // Sticky error flag, cleared only by a good transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

    // Pending/commit: a new load keeps pending set even when a frame tick commits older data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            commit  <= 1'b0;
        end else begin
            commit <= frame_tick & pending;
            if (load_pov || load_opt) pending <= 1'b1;
            else if (frame_tick)      pending <= 1'b0;
        end
    end

    // Frame-boundary copy of the staging register to the renderer-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            player_x <= RESET_PX;
            player_y <= RESET_PY;
            facing_x <= RESET_FX;
            facing_y <= RESET_FY;
            opts     <= RESET_OPTS;
        end else if (frame_tick && pending) begin
            player_x <= stg_px;
            player_y <= stg_py;
            facing_x <= stg_fx;
            facing_y <= stg_fy;
            opts     <= stg_opts;
        end
    end

endmodule

// File: tb/tb_pov_spi_loader.sv
// Directed bench for pov_spi_loader: SPI writes at sclk = clk/4, frame commits,
// malformed transactions and the completion/frame-tick collision.
module tb_pov_spi_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vsync_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic [15:0] player_x, player_y, facing_x, facing_y;
    logic [2:0]  opts;
    logic        pending, commit, err;

    int n_checks = 0;
    int n_fail   = 0;
    int commit_cnt = 0;

    pov_spi_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vsync_n  (vsync_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .player_x (player_x),
        .player_y (player_y),
        .facing_x (facing_x),
        .facing_y (facing_y),
        .opts     (opts),
        .pending  (pending),
        .commit   (commit),
        .err      (err)
    );

    always #20 clk = ~clk;

    // Count cycles in which commit is high, sampled mid-cycle.
    always @(negedge clk) if (commit === 1'b1) commit_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(2);
        sclk = 1'b1;
        tick(2);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_pov(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        send_word(a); send_word(b); send_word(c); send_word(d);
    endtask

    task automatic spi_start();
        ss_n = 1'b0;
        tick(4);
    endtask

    task automatic spi_stop();
        tick(2);
        ss_n = 1'b1;
        tick(5);
    endtask

    task automatic frame();
        vsync_n = 1'b0;
        tick(4);
        vsync_n = 1'b1;
        tick(4);
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #3;
        check("rst_px",      player_x, 16'h0180);
        check("rst_py",      player_y, 16'h0180);
        check("rst_fx",      facing_x, 16'h0100);
        check("rst_fy",      facing_y, 16'h0000);
        check("rst_opts",    opts,     3'b001);
        check("rst_pending", pending,  1'b0);
        check("rst_err",     err,      1'b0);
        check("rst_commit",  commit,   1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(4);

        // POV write; outputs hold until the frame boundary, then update 3 clk after the pin edge.
        spi_start();
        send_byte(8'h01);
        send_pov(16'h0200, 16'h0300, 16'h0000, 16'h0100);
        spi_stop();
        check("pov_pending",  pending,  1'b1);
        check("pov_err",      err,      1'b0);
        check("pov_hold_px",  player_x, 16'h0180);
        vsync_n = 1'b0;
        tick(2);
        check("pov_early_px",     player_x, 16'h0180);
        check("pov_early_commit", commit,   1'b0);
        tick(1);
        check("pov_px",       player_x, 16'h0200);
        check("pov_py",       player_y, 16'h0300);
        check("pov_fx",       facing_x, 16'h0000);
        check("pov_fy",       facing_y, 16'h0100);
        check("pov_commit",   commit,   1'b1);
        check("pov_pend_clr", pending,  1'b0);
        tick(1);
        check("pov_commit_1cyc", commit, 1'b0);
        vsync_n = 1'b1;
        tick(4);
        check("pov_commit_cnt", commit_cnt, 1);

        // Options write leaves the POV alone.
        spi_start();
        send_byte(8'h02);
        send_byte(8'h06);
        spi_stop();
        check("opt_pending", pending, 1'b1);
        frame();
        check("opt_opts",       opts,       3'b110);
        check("opt_px_kept",    player_x,   16'h0200);
        check("opt_fy_kept",    facing_y,   16'h0100);
        check("opt_commit_cnt", commit_cnt, 2);

        // Truncated POV payload (40 bits): error, nothing staged, no commit.
        spi_start();
        send_byte(8'h01);
        send_word(16'h1111);
        send_word(16'h2222);
        send_byte(8'h33);
        spi_stop();
        check("trunc_err",     err,     1'b1);
        check("trunc_pending", pending, 1'b0);
        frame();
        check("trunc_px",         player_x,   16'h0200);
        check("trunc_commit_cnt", commit_cnt, 2);

        // Good options write clears the error.
        spi_start();
        send_byte(8'h02);
        send_byte(8'h03);
        spi_stop();
        check("opt2_err",     err,     1'b0);
        check("opt2_pending", pending, 1'b1);
        frame();
        check("opt2_opts", opts, 3'b011);

        // Unknown command sets err; following bits are ignored.
        spi_start();
        send_byte(8'h55);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        spi_stop();
        check("badcmd_err",     err,     1'b1);
        check("badcmd_pending", pending, 1'b0);
        spi_start();
        send_byte(8'h02);
        send_byte(8'h01);
        spi_stop();
        check("recover_err",     err,     1'b0);
        check("recover_pending", pending, 1'b1);
        frame();
        check("recover_opts",       opts,       3'b001);
        check("recover_commit_cnt", commit_cnt, 4);

        // Over-length options payload (9 bits): error, nothing staged.
        spi_start();
        send_byte(8'h02);
        send_byte(8'hFF);
        send_bit(1'b1);
        spi_stop();
        check("over_err",     err,     1'b1);
        check("over_pending", pending, 1'b0);

        // Completion coinciding with the frame tick while an earlier update is pending.
        spi_start();
        send_byte(8'h01);
        send_pov(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        spi_stop();
        check("coll_a_pending", pending, 1'b1);
        check("coll_a_err",     err,     1'b0);
        spi_start();
        send_byte(8'h01);
        send_pov(16'h5555, 16'h6666, 16'h7777, 16'h0008);
        tick(2);
        ss_n    = 1'b1;
        vsync_n = 1'b0;
        tick(5);
        vsync_n = 1'b1;
        tick(4);
        check("coll_px_a",      player_x,   16'h1111);
        check("coll_fy_a",      facing_y,   16'h4444);
        check("coll_pending",   pending,    1'b1);
        check("coll_commit_cnt", commit_cnt, 5);
        frame();
        check("coll_px_b",      player_x,   16'h5555);
        check("coll_py_b",      player_y,   16'h6666);
        check("coll_fx_b",      facing_x,   16'h7777);
        check("coll_fy_b",      facing_y,   16'h0008);
        check("coll_opts",      opts,       3'b001);
        check("coll_pend_clr",  pending,    1'b0);
        check("coll_commit_cnt2", commit_cnt, 6);

        // Select with no bits is silently discarded.
        spi_start();
        spi_stop();
        check("empty_err",     err,     1'b0);
        check("empty_pending", pending, 1'b0);

        // Reset in the middle of a POV write abandons everything.
        spi_start();
        send_byte(8'h01);
        send_word(16'hABCD);
        reset_n = 1'b0;
        ss_n    = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("midrst_px",      player_x, 16'h0180);
        check("midrst_pending", pending,  1'b0);
        check("midrst_err",     err,      1'b0);
        frame();
        check("midrst_px_frame",   player_x,   16'h0180);
        check("midrst_commit_cnt", commit_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
